// File: rtl/data_mem_responder_pkg.sv
// Purpose : shared types and constants for the data-memory responder slice.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package mem_resp_pkg;

  localparam int STRB_W    = 4;
  localparam int DATA_W    = 32;
  localparam int LAT_CNT_W = 4;

  // Fibonacci LFSR for optional request back-pressure (taps 8,6,5,4).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Purpose : 2**ADDR_WIDTH x 32 word RAM with one write enable per byte lane.
// Latency : write lands at the clock edge; read is combinational.
// Backpr. : none, every enabled write is taken.
// Ports   : clk; we[3:0] per-lane enables; waddr/wdata write side; raddr/rdata read side.
module byte_lane_ram
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [STRB_W-1:0]     we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Purpose : memory-side responder for the core data port (byte-strobed writes, full-word reads).
// Latency : writes take effect at the accept edge; Read_data_Valid rises READ_LATENCY cycles after a read accept.
// Backpr. : Mem_Req_Ack low while a read is outstanding; with MEM_ACK_STALL_EN an LFSR also stalls IDLE.
// Ports   : clk, rst (async, active-high); MemWrite/MemRead/Address/Write_data/Write_strb request side,
//           Mem_Req_Ack accept; Read_data/Read_data_Valid response, Read_data_Ack consume.
// Option  : `define MEM_ACK_STALL_EN to enable random request back-pressure in IDLE.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  output logic              Mem_Req_Ack,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ack
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [LAT_CNT_W-1:0]    lat_cnt;
  logic [ADDR_WIDTH-1:0]   req_idx, rd_idx, ram_raddr;
  logic [DATA_W-1:0]       ram_rdata;
  logic [STRB_W-1:0]       ram_we;
  logic                    idle_ack, wr_acc, rd_acc, load_rd;
  logic                    unused_addr_bits;

  // Upper address bits are dropped so accesses wrap modulo the RAM depth.
  assign req_idx          = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef MEM_ACK_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign idle_ack = ~lfsr[0];
`else
  assign idle_ack = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    Mem_Req_Ack = 1'b0;
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    load_rd     = 1'b0;
    case (state)
      IDLE: begin
        Mem_Req_Ack = idle_ack;
        // A simultaneous read is dropped: write wins, requester retries the read.
        if (MemWrite && idle_ack) begin
          wr_acc = 1'b1;
        end else if (MemRead && idle_ack) begin
          rd_acc = 1'b1;
          if (READ_LATENCY == 1) begin
            load_rd   = 1'b1;
            state_nxt = RD_RESP;
          end else begin
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_CNT_W'(1)) begin
          load_rd   = 1'b1;
          state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        if (Read_data_Ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the RAM is read at the incoming address so a latency-1 read can load directly.
  assign ram_raddr       = (state == IDLE) ? req_idx : rd_idx;
  assign ram_we          = wr_acc ? Write_strb : '0;
  assign Read_data_Valid = (state == RD_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt   <= '0;
      rd_idx    <= '0;
      Read_data <= '0;
    end else begin
      if (rd_acc) begin
        lat_cnt <= LAT_INIT;
        rd_idx  <= req_idx;
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt - LAT_CNT_W'(1);
      end
      if (load_rd) Read_data <= ram_rdata;
    end
  end

  byte_lane_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (req_idx),
    .wdata (Write_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : randomized scoreboard bench for data_mem_responder against a word-array model.
// Latency : expects Read_data_Valid exactly READ_LATENCY cycles after each read accept.
// Backpr. : requester retries until Mem_Req_Ack; requests issued while busy must be ignored.
module tb_data_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0, MemRead = 1'b0, Read_data_Ack = 1'b0;
  logic [31:0] Address = '0, Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        Mem_Req_Ack, Read_data_Valid;
  logic [31:0] Read_data;

  data_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] mdl [2**AW];
  logic [31:0] exp_q [$];
  bit          exp_busy = 0;     // a read is outstanding in the cycle the monitor samples
  int          ready_pc = 0;     // posedge count at which the response must be visible
  int          pcount   = 0;
  bit          in_reset = 1;
  bit          have_cur = 0;
  logic [31:0] cur_exp;
  int          errors = 0, checks = 0;

  always @(posedge clk) pcount = pcount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // Monitor: compares DUT outputs against the model once per cycle.
  bit exp_v;
  always @(negedge clk) begin
    #1;
    if (!in_reset) begin
      exp_v = exp_busy && (pcount >= ready_pc);
      chk("valid", {31'b0, Read_data_Valid}, {31'b0, exp_v});
`ifdef MEM_ACK_STALL_EN
      if (exp_busy) chk("req_ack_busy", {31'b0, Mem_Req_Ack}, 32'd0);
`else
      chk("req_ack", {31'b0, Mem_Req_Ack}, {31'b0, !exp_busy});
`endif
      if (Read_data_Valid && exp_v) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            cur_exp = 'x;
          end else begin
            cur_exp = exp_q.pop_front();
          end
          have_cur = 1;
        end
        chk("read_data", Read_data, cur_exp);
      end
      if (!exp_v) have_cur = 0;
    end
  end

  // One requester cycle; acceptance follows the handshake rules on the model side.
  task automatic step(input logic mw, input logic mr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic rack,
                      output bit acc);
    @(negedge clk); #2;
    MemWrite = mw; MemRead = mr; Address = a; Write_data = wd; Write_strb = st;
    Read_data_Ack = rack;
    acc = 0;
    if (!exp_busy) begin
      if (Mem_Req_Ack && (mw || mr)) begin
        acc = 1;
        if (mw) begin
          for (int i = 0; i < 4; i++)
            if (st[i]) mdl[widx(a)][8*i +: 8] = wd[8*i +: 8];
        end else begin
          exp_q.push_back(mdl[widx(a)]);
          exp_busy = 1;
          ready_pc = pcount + LAT;
        end
      end
    end else if (rack && pcount >= ready_pc) begin
      exp_busy = 0;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 4'h0, 0, acc);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic also_rd);
    bit acc = 0;
    for (int t = 0; t < 64 && !acc; t++) step(1, also_rd, a, d, s, 0, acc);
    if (!acc) chk("write_timeout", 32'd0, 32'd1);
  endtask

  // hold: extra cycles the response stays unacknowledged; poke: issue a write while busy.
  task automatic do_read(input logic [31:0] a, input int hold, input logic poke);
    bit acc = 0;
    bit dummy;
    logic r;
    for (int t = 0; t < 64 && !acc; t++) step(0, 1, a, 32'h0, 4'h0, 0, acc);
    if (!acc) begin
      chk("read_accept_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 64 && exp_busy; i++) begin
      if (pcount + 1 >= ready_pc + hold) r = 1'b1;
      else if (pcount + 1 < ready_pc)    r = 1'($urandom_range(0, 1));  // ack before valid: ignored
      else                               r = 1'b0;
      step(poke, 0, a, 32'hDEAD_0000 ^ $urandom(), 4'hF, r, dummy);
    end
    if (exp_busy) chk("read_resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_now(input int cycles);
    in_reset = 1;
    rst = 1;
    exp_q.delete();
    exp_busy = 0;
    have_cur = 0;
    #1;
    chk("rst_valid", {31'b0, Read_data_Valid}, 32'd0);
    chk("rst_rdata", Read_data, 32'h0);
`ifndef MEM_ACK_STALL_EN
    chk("rst_req_ack", {31'b0, Mem_Req_Ack}, 32'd1);
`endif
    repeat (cycles) @(negedge clk);
    #2;
    MemWrite = 0; MemRead = 0; Read_data_Ack = 0;
    rst = 0;
    in_reset = 0;
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < 2**AW; i++) mdl[i] = 'x;
    reset_now(3);

    // RAM contents survive reset.
    do_write(32'h10, 32'h1122_3344, 4'hF, 0);
    @(negedge clk); #2;
    reset_now(2);
    do_read(32'h10, 0, 0);

    // Byte-lane merges, including an empty strobe and address aliasing.
    do_write(32'h20, 32'hAABB_CCDD, 4'b1111, 0);
    do_write(32'h20, 32'h0000_EE00, 4'b0010, 0);
    do_write(32'h20, 32'h9900_0000, 4'b1000, 0);
    do_read (32'h20, 0, 0);
    do_write(32'h20, 32'h5555_5555, 4'b0000, 0);
    do_read (32'h20, 1, 0);
    do_write(32'h0,    32'h0BAD_F00D, 4'hF, 0);
    do_write(32'h1000, 32'hC0DE_0001, 4'hF, 0);
    do_read (32'h0, 0, 0);

    // Read and write together: write wins, then read-after-write next cycle.
    do_write(32'h30, 32'h1234_5678, 4'hF, 1);
    do_read (32'h30, 0, 0);

    // Long unacknowledged response with a write attempt that must be ignored.
    do_read (32'h30, 5, 1);
    do_read (32'h30, 0, 0);

    // Reset while a read is waiting.
    step(0, 1, 32'h20, 32'h0, 4'h0, 0, acc);
    while (!acc && exp_busy == 0 && pcount < 100000) step(0, 1, 32'h20, 32'h0, 4'h0, 0, acc);
    @(negedge clk); #2;
    reset_now(2);
    do_read(32'h20, 0, 0);

    // Randomized traffic over 16 words with aliasing address bits.
    for (int w = 0; w < 16; w++) do_write(w << 2, $urandom(), 4'hF, 0);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
